// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Folded FIR controller. A single signed multiply-accumulate unit
//            is stepped across all TAPS taps of the filter for each accepted
//            sample. The block holds the circular sample history and a
//            coefficient bank that can be written at run time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-high reset, clears all state
//   x_i          signed input sample (DATA_W)
//   x_valid_i    sample offered
//   x_ready_o    sample taken when x_valid_i & x_ready_o
//   coef_we_i    coefficient write strobe
//   coef_addr_i  tap index of the coefficient write
//   coef_data_i  signed coefficient value (COEF_W)
//   coef_err_o   one-cycle pulse, the cycle after a rejected write
//   y_o          signed filter result (ACC_W)
//   y_valid_o    result available
//   y_ready_i    result consumed when y_valid_o & y_ready_i
//   busy_o       a sample is being processed or its result is pending
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS   = 129,
    parameter int DATA_W = 33,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 58
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [DATA_W-1:0]  x_i,
    input  logic                      x_valid_i,
    output logic                      x_ready_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(TAPS)-1:0]   coef_addr_i,
    input  logic signed [COEF_W-1:0]  coef_data_i,
    output logic                      coef_err_o,
    output logic signed [ACC_W-1:0]   y_o,
    output logic                      y_valid_o,
    input  logic                      y_ready_i,
    output logic                      busy_o
);

    localparam int              c_AW   = $clog2(TAPS);
    localparam int              c_PW   = DATA_W + COEF_W;
    localparam logic [c_AW-1:0] c_LAST = c_AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] hist_q [TAPS];
    logic [c_AW-1:0]          wp_q;
    logic [c_AW-1:0]          rd_q;
    logic [c_AW-1:0]          k_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     coef_err_q;

    logic                     w_x_hs;
    logic                     w_last;
    logic                     w_coef_ok;
    logic                     w_coef_err;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;

    // A coefficient write is only safe while no computation is in flight and
    // no new sample is starting in the same cycle; anything else is refused.
    assign w_x_hs     = (state_q == IDLE) && x_valid_i;
    assign w_last     = (k_q == c_LAST);
    assign w_coef_ok  = coef_we_i && (state_q == IDLE) && !w_x_hs
                        && (coef_addr_i <= c_LAST);
    assign w_coef_err = coef_we_i && !w_coef_ok;

    // Full-precision product, sign-extended; the accumulator wraps.
    assign w_prod     = coef_q[k_q] * hist_q[rd_q];
    assign w_prod_ext = {{(ACC_W - c_PW){w_prod[c_PW-1]}}, w_prod};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_x_hs)    state_d = RUN;
            RUN:     if (w_last)    state_d = DONE;
            DONE:    if (y_ready_i) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // x_ready is masked by reset so the source never sees a ready while the
    // block is held in reset.
    always_comb begin
        x_ready_o  = (state_q == IDLE) && !reset_i;
        y_valid_o  = (state_q == DONE);
        busy_o     = (state_q != IDLE);
        y_o        = acc_q;
        coef_err_o = coef_err_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            rd_q       <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            coef_err_q <= w_coef_err;
            if (w_coef_ok) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
            case (state_q)
                IDLE: begin
                    if (w_x_hs) begin
                        hist_q[wp_q] <= x_i;
                        acc_q        <= '0;
                        k_q          <= '0;
                        rd_q         <= wp_q;
                    end
                end
                RUN: begin
                    acc_q <= acc_q + w_prod_ext;
                    k_q   <= k_q + 1'b1;
                    // Walk backwards through history: newest sample pairs
                    // with tap 0.
                    rd_q  <= (rd_q == '0) ? c_LAST : rd_q - 1'b1;
                    if (w_last) begin
                        wp_q <= (wp_q == c_LAST) ? '0 : wp_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Self-checking bench for fir_mac_sequencer. Results are compared
//            against a convolution of the accepted samples with the bank of
//            coefficients the bench believes was written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int TAPS   = 129;
    localparam int DATA_W = 33;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 58;
    localparam int AW     = $clog2(TAPS);

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic signed [DATA_W-1:0] x_i;
    logic                     x_valid_i;
    logic                     x_ready_o;
    logic                     coef_we_i;
    logic [AW-1:0]            coef_addr_i;
    logic signed [COEF_W-1:0] coef_data_i;
    logic                     coef_err_o;
    logic [ACC_W-1:0]         y_o;
    logic                     y_valid_o;
    logic                     y_ready_i;
    logic                     busy_o;

    int     checks = 0;
    int     errors = 0;
    longint coefm [TAPS];
    longint xs [$];

    fir_mac_sequencer #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .x_i         (x_i),
        .x_valid_i   (x_valid_i),
        .x_ready_o   (x_ready_o),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i),
        .coef_err_o  (coef_err_o),
        .y_o         (y_o),
        .y_valid_o   (y_valid_o),
        .y_ready_i   (y_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // y[n] = sum_k coef[k] * x[n-k]; samples older than reset count as zero.
    function automatic logic [ACC_W-1:0] model_y();
        longint      s;
        logic [63:0] t;
        int          n;
        s = 0;
        n = xs.size();
        for (int k = 0; k < TAPS && k < n; k++) s += coefm[k] * xs[n-1-k];
        t = s;
        return t[ACC_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] rand_x();
        logic [63:0] r;
        int unsigned sel;
        r   = {$urandom(), $urandom()};
        sel = $urandom_range(0, 9);
        if (sel == 0) return {1'b1, {(DATA_W-1){1'b0}}};
        if (sel == 1) return {1'b0, {(DATA_W-1){1'b1}}};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic signed [COEF_W-1:0] rand_c();
        logic [31:0] r;
        r = $urandom();
        if (r[31:29] == 3'd0) return {1'b1, {(COEF_W-1){1'b0}}};
        return r[COEF_W-1:0];
    endfunction

    task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] data, input bit bad);
        coef_we_i   = 1'b1;
        coef_addr_i = AW'(addr);
        coef_data_i = data;
        tick();
        coef_we_i = 1'b0;
        chk("coef_err_write", coef_err_o, bad);
        if (!bad) coefm[addr] = longint'(data);
        else begin
            tick();
            chk("coef_err_clear", coef_err_o, 0);
        end
    endtask

    task automatic do_sample(input logic signed [DATA_W-1:0] xv, input int bp,
                             input bit collide, input bit bad_run);
        int               n;
        int               a;
        logic [63:0]      tmp;
        logic [ACC_W-1:0] exp_y;
        logic [ACC_W-1:0] y_hold;
        n = 0;
        while (!x_ready_o && n < 8) begin
            tick();
            n++;
        end
        chk("x_ready_idle", x_ready_o, 1);
        x_i       = xv;
        x_valid_i = 1'b1;
        if (collide) begin
            a           = int'($urandom_range(0, TAPS-1));
            tmp         = coefm[a];
            coef_we_i   = 1'b1;
            coef_addr_i = AW'(a);
            coef_data_i = tmp[COEF_W-1:0] ^ 16'h5a5a;
        end
        tick();
        x_valid_i = 1'b0;
        coef_we_i = 1'b0;
        xs.push_back(longint'(xv));
        if (xs.size() > TAPS) void'(xs.pop_front());
        exp_y = model_y();
        if (collide) chk("coef_err_collide", coef_err_o, 1);
        chk("busy_run", busy_o, 1);
        chk("x_ready_run", x_ready_o, 0);
        n = 0;
        if (bad_run) begin
            a           = int'($urandom_range(0, TAPS-1));
            tmp         = coefm[a];
            coef_we_i   = 1'b1;
            coef_addr_i = AW'(a);
            coef_data_i = tmp[COEF_W-1:0] ^ 16'h0ff1;
            tick();
            coef_we_i = 1'b0;
            n = 1;
            chk("coef_err_run", coef_err_o, 1);
        end
        while (!y_valid_o && n < TAPS + 8) begin
            tick();
            n++;
        end
        chk("latency", n, TAPS);
        chk("y", y_o, exp_y);
        y_hold = y_o;
        for (int i = 0; i < bp; i++) begin
            y_ready_i = 1'b0;
            tick();
            chk("bp_y_valid", y_valid_o, 1);
            chk("bp_y_stable", y_o, y_hold);
            chk("bp_x_ready", x_ready_o, 0);
        end
        y_ready_i = 1'b1;
        tick();
        chk("post_hs_y_valid", y_valid_o, 0);
        chk("post_hs_busy", busy_o, 0);
    endtask

    initial begin
        int bp;
        reset_i     = 1'b1;
        x_i         = '0;
        x_valid_i   = 1'b0;
        coef_we_i   = 1'b0;
        coef_addr_i = '0;
        coef_data_i = '0;
        y_ready_i   = 1'b1;
        for (int i = 0; i < TAPS; i++) coefm[i] = 0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_x_ready", x_ready_o, 0);
        chk("rst_y_valid", y_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_coef_err", coef_err_o, 0);
        chk("rst_y", y_o, 0);
        reset_i = 1'b0;
        tick();
        chk("rel_x_ready", x_ready_o, 1);

        // Zero bank straight out of reset.
        do_sample(1, 0, 1'b0, 1'b0);

        for (int i = 0; i < TAPS; i++) write_coef(i, rand_c(), 1'b0);
        write_coef(TAPS, 16'h1111, 1'b1);

        // Randomised run long enough to wrap the history pointer.
        for (int s = 0; s < TAPS + 3; s++) begin
            bp = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 2));
            do_sample(rand_x(), bp, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a computation at k = 50.
        x_i       = rand_x();
        x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        repeat (50) tick();
        chk("mid_busy", busy_o, 1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_y_valid", y_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_x_ready", x_ready_o, 0);
        tick();
        reset_i = 1'b0;
        xs.delete();
        for (int i = 0; i < TAPS; i++) coefm[i] = 0;
        tick();
        chk("mid_rel_x_ready", x_ready_o, 1);
        do_sample(1, 0, 1'b0, 1'b0);

        // Symmetric bank, then an impulse followed by zeros.
        for (int i = 0; i <= (TAPS - 1) / 2; i++) begin
            logic signed [COEF_W-1:0] c;
            c = rand_c();
            write_coef(i, c, 1'b0);
            if (TAPS - 1 - i != i) write_coef(TAPS - 1 - i, c, 1'b0);
        end
        do_sample(1, 0, 1'b0, 1'b0);
        for (int s = 1; s < TAPS; s++) do_sample(0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
